// File: rtl/uart_pkg.sv
// Shared UART constants and the baud divisor type, imported by every UART block.
package uart_pkg;

    localparam int UART_DIV_W        = 16;
    localparam int UART_FRAC_W       = 4;
    localparam int UART_OS           = 16;
    // 50 MHz / (19200 * 16) = 162.76 -> 162 + 12/16
    localparam int UART_DEF_DIV_INT  = 162;
    localparam int UART_DEF_DIV_FRAC = 12;

    typedef struct packed {
        logic [UART_DIV_W-1:0]  div_int;
        logic [UART_FRAC_W-1:0] div_frac;
    } baud_div_t;

    localparam baud_div_t UART_DEF_DIV = {UART_DIV_W'(UART_DEF_DIV_INT),
                                          UART_FRAC_W'(UART_DEF_DIV_FRAC)};

endpackage

// File: rtl/uart_baud_gen_frac_if.sv
// Control and tick bundle between the baud generator and the UART datapath.
interface uart_baud_gen_frac_if
    import uart_pkg::*;
#(
    parameter int DIV_W  = UART_DIV_W,
    parameter int FRAC_W = UART_FRAC_W,
    parameter int OS     = UART_OS
);
    localparam int PH_W = $clog2(OS);

    logic              en;
    logic [DIV_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic              div_load;
    logic              sync;
    logic              tick_os;
    logic              tick_bit;
    logic [PH_W-1:0]   os_phase;

    modport master (
        output en, div_int, div_frac, div_load, sync,
        input  tick_os, tick_bit, os_phase
    );

    modport slave (
        input  en, div_int, div_frac, div_load, sync,
        output tick_os, tick_bit, os_phase
    );

endinterface

// File: rtl/uart_os_counter.sv
// Oversample phase counter; emits the bit tick on the last oversample of each bit.
module uart_os_counter
    import uart_pkg::*;
#(
    parameter int OS = UART_OS
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  sync,
    input  logic                  tick_os,
    output logic [$clog2(OS)-1:0] os_phase,
    output logic                  tick_bit
);
    localparam int PH_W = $clog2(OS);

    logic [PH_W-1:0] phase_reg;
    logic [PH_W-1:0] phase_next;

    // A start edge lands the phase mid-bit so the first bit tick samples the centre.
    always_comb begin
        phase_next = phase_reg;
        if (en && sync) begin
            phase_next = PH_W'(OS / 2);
        end else if (tick_os) begin
            phase_next = phase_reg + PH_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_reg <= '0;
        end else begin
            phase_reg <= phase_next;
        end
    end

    assign os_phase = phase_reg;
    assign tick_bit = tick_os && (phase_reg == PH_W'(OS - 1));

endmodule

// File: rtl/uart_baud_gen_frac.sv
// Fractional-N baud generator: integer down-counter stretched by one cycle on
// each carry of the fractional accumulator, with a shadowed runtime divisor.
module uart_baud_gen_frac
    import uart_pkg::*;
#(
    parameter int DIV_W        = UART_DIV_W,
    parameter int FRAC_W       = UART_FRAC_W,
    parameter int OS           = UART_OS,
    parameter int DEF_DIV_INT  = UART_DEF_DIV_INT,
    parameter int DEF_DIV_FRAC = UART_DEF_DIV_FRAC
)(
    input  logic               clk,
    input  logic               reset,
    uart_baud_gen_frac_if.slave bus
);
    localparam int PH_W = $clog2(OS);

    typedef struct packed {
        logic [DIV_W-1:0]  div_int;
        logic [FRAC_W-1:0] div_frac;
    } div_val_t;

    localparam div_val_t DEF_DIV = {DIV_W'(DEF_DIV_INT), FRAC_W'(DEF_DIV_FRAC)};

    div_val_t          act_reg, act_next;
    div_val_t          shadow_reg, shadow_next;
    div_val_t          load_val;
    div_val_t          eff;
    logic              pend_reg, pend_next;
    logic [DIV_W-1:0]  cnt_reg, cnt_next;
    logic [FRAC_W-1:0] acc_reg, acc_next;
    logic [FRAC_W-1:0] acc_sum;
    logic              carry;
    logic              tick_os;
    logic              sync_act;
    logic              reload;
    logic              take;
    logic [PH_W-1:0]   os_phase;
    logic              tick_bit;

    always_comb begin
        load_val.div_int  = (bus.div_int < DIV_W'(2)) ? DIV_W'(2) : bus.div_int;
        load_val.div_frac = bus.div_frac;

        tick_os  = bus.en && (cnt_reg == '0) && !bus.sync;
        sync_act = bus.en && bus.sync;
        // Any cycle where the count is not running mid-period may swap the divisor.
        reload   = tick_os || sync_act || !bus.en;
        take     = reload && (pend_reg || bus.div_load);
        eff      = take ? (bus.div_load ? load_val : shadow_reg) : act_reg;

        {carry, acc_sum} = {1'b0, acc_reg} + {1'b0, eff.div_frac};

        shadow_next = bus.div_load ? load_val : shadow_reg;
        act_next    = eff;
        pend_next   = take ? 1'b0 : (pend_reg || bus.div_load);

        cnt_next = cnt_reg;
        acc_next = acc_reg;
        if (sync_act) begin
            cnt_next = eff.div_int - DIV_W'(1);
            acc_next = '0;
        end else if (tick_os) begin
            // Modular arithmetic keeps int_max + carry - 1 exact in DIV_W bits.
            cnt_next = eff.div_int + {{(DIV_W-1){1'b0}}, carry} - DIV_W'(1);
            acc_next = acc_sum;
        end else if (bus.en) begin
            cnt_next = cnt_reg - DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            act_reg    <= DEF_DIV;
            shadow_reg <= DEF_DIV;
            pend_reg   <= 1'b0;
            cnt_reg    <= DIV_W'(DEF_DIV_INT - 1);
            acc_reg    <= '0;
        end else begin
            act_reg    <= act_next;
            shadow_reg <= shadow_next;
            pend_reg   <= pend_next;
            cnt_reg    <= cnt_next;
            acc_reg    <= acc_next;
        end
    end

    uart_os_counter #(
        .OS (OS)
    ) u_os_counter (
        .clk      (clk),
        .reset    (reset),
        .en       (bus.en),
        .sync     (bus.sync),
        .tick_os  (tick_os),
        .os_phase (os_phase),
        .tick_bit (tick_bit)
    );

    assign bus.tick_os  = tick_os;
    assign bus.tick_bit = tick_bit;
    assign bus.os_phase = os_phase;

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Directed bench for uart_baud_gen_frac: closed-form tick-time model plus literal checks.
module tb_uart_baud_gen_frac;

    localparam int DIV_W  = 16;
    localparam int FRAC_W = 4;
    localparam int OS     = 16;
    localparam int DEF_I  = 162;
    localparam int DEF_F  = 12;
    localparam int FSCALE = 1 << FRAC_W;

    logic clk;
    logic reset;

    uart_baud_gen_frac_if #(.DIV_W(DIV_W), .FRAC_W(FRAC_W), .OS(OS)) bus ();

    uart_baud_gen_frac #(
        .DIV_W        (DIV_W),
        .FRAC_W       (FRAC_W),
        .OS           (OS),
        .DEF_DIV_INT  (DEF_I),
        .DEF_DIV_FRAC (DEF_F)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: tick k after an anchor tick at enabled-cycle anc_e lands at
    // anc_e + k*I + floor((a + k*F) / 2^FRAC_W), a being the accumulator at the anchor.
    int m_ecyc, m_next, m_anc_e, m_anc_a, m_n, m_hold_a, m_phase;
    int m_ai, m_af, m_si, m_sf;
    bit m_anch, m_pend;

    task automatic mcheck(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL model %s @cycle %0d: got %0d, expected %0d", name, cyc, got, exp);
        end
    endtask

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end else begin
            $display("ok   %s = %0d", name, got);
        end
    endtask

    task automatic model_init();
        m_ecyc = 0; m_next = DEF_I - 1; m_anch = 0; m_hold_a = 0;
        m_anc_e = 0; m_anc_a = 0; m_n = 0; m_phase = 0;
        m_ai = DEF_I; m_af = DEF_F; m_si = DEF_I; m_sf = DEF_F; m_pend = 0;
    endtask

    // Called once per cycle at the falling edge, while inputs are stable.
    task automatic model_step();
        int li, lf, ni, nf, cur_a;
        bit en, sy, ld, et, eb, take;
        cyc++;
        if (!reset) begin
            model_init();
            mcheck("rst_tick_os", int'(bus.tick_os), 0);
            mcheck("rst_tick_bit", int'(bus.tick_bit), 0);
            mcheck("rst_os_phase", int'(bus.os_phase), 0);
            return;
        end
        en = bus.en; sy = bus.sync; ld = bus.div_load;
        li = (int'(bus.div_int) < 2) ? 2 : int'(bus.div_int);
        lf = int'(bus.div_frac);
        et = en && !sy && (m_ecyc == m_next);
        eb = et && (m_phase == OS - 1);
        mcheck("tick_os", int'(bus.tick_os), int'(et));
        mcheck("tick_bit", int'(bus.tick_bit), int'(eb));
        mcheck("os_phase", int'(bus.os_phase), m_phase);

        take  = (et || (en && sy) || !en) && (m_pend || ld);
        ni    = ld ? li : m_si;
        nf    = ld ? lf : m_sf;
        cur_a = m_anch ? (m_anc_a + m_n * m_af) % FSCALE : m_hold_a;
        if (ld) begin m_si = li; m_sf = lf; end
        if (take) begin m_ai = ni; m_af = nf; m_pend = 0; end
        else if (ld) m_pend = 1;

        if (en && sy) begin
            m_next = m_ecyc + m_ai; m_anch = 0; m_hold_a = 0; m_phase = OS / 2;
        end else if (et) begin
            if (!m_anch || take) begin
                m_anc_e = m_ecyc; m_anc_a = cur_a; m_n = 0; m_anch = 1;
            end
            m_n++;
            m_next  = m_anc_e + m_n * m_ai + (m_anc_a + m_n * m_af) / FSCALE;
            m_phase = (m_phase + 1) % OS;
        end else if (take && m_anch) begin
            m_hold_a = cur_a; m_anch = 0;
        end
        if (en) m_ecyc++;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk); model_step();
            @(posedge clk); #1;
        end
    endtask

    // Returns the 1-based cycle (from the call) carrying tick_os, or -1 on timeout.
    task automatic wait_tick(input int limit, output int n, output bit b);
        n = -1; b = 0;
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk); model_step();
            if (bus.tick_os) begin
                n = k; b = bus.tick_bit;
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
        checks++; errors++;
        $display("FAIL wait_tick: no tick_os within %0d cycles, required one", limit);
    endtask

    task automatic pulse_load(input int i, input int f);
        bus.div_int = DIV_W'(i); bus.div_frac = FRAC_W'(f); bus.div_load = 1'b1;
        step(1);
        bus.div_load = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, sum, c163, bits, bitpos, idx, dis_ticks;
        bit b;
        reset = 1'b0; bus.en = 1'b1; bus.sync = 1'b0; bus.div_load = 1'b0;
        bus.div_int = '0; bus.div_frac = '0;
        model_init();
        @(posedge clk); #1;
        step(3);
        reset = 1'b1;

        // Default divisor 162 + 12/16
        wait_tick(400, n, b); check("first_tick_cycle", n, 162);
        sum = 0; c163 = 0; bits = 0; bitpos = 0;
        for (int k = 2; k <= 17; k++) begin
            wait_tick(400, n, b);
            sum += n;
            if (n == 163) c163++;
            if (b) begin bits++; bitpos = k - 1; end
        end
        check("sum_16_periods", sum, 2604);
        check("periods_of_163", c163, 12);
        check("tick_bit_count", bits, 1);
        check("tick_bit_on_os_tick", bitpos, 15);

        // Mid-period load: old period completes, then period 3
        step(5); pulse_load(3, 0);
        wait_tick(400, n, b); check("old_period_rest", n, 156);
        wait_tick(20, n, b);  check("period_3_a", n, 3);
        wait_tick(20, n, b);  check("period_3_b", n, 3);

        // Load of 0 on a tick cycle: clamped to 2 and effective immediately
        step(2); pulse_load(0, 0);
        wait_tick(20, n, b); check("clamp_period_a", n, 2);
        wait_tick(20, n, b); check("clamp_period_b", n, 2);

        // 4 + 8/16: any two consecutive periods total 9
        pulse_load(4, 8);
        wait_tick(20, n, b); check("load_4_8_tick", n, 1);
        wait_tick(20, n, b); sum = n;
        wait_tick(20, n, b); sum += n;
        check("two_periods_4p5", sum, 9);

        // Sync at os_phase 5
        pulse_load(10, 0);
        wait_tick(20, n, b);
        for (int k = 0; k < 40 && bus.os_phase != 5; k++) wait_tick(20, n, b);
        check("reached_phase_5", int'(bus.os_phase), 5);
        step(3);
        bus.sync = 1'b1; step(1); bus.sync = 1'b0;
        check("phase_after_sync", int'(bus.os_phase), 8);
        wait_tick(30, n, b); check("sync_to_tick", n, 10);
        idx = b ? 1 : 0;
        for (int k = 2; k <= 8; k++) begin
            wait_tick(30, n, b);
            if (b && idx == 0) idx = k;
        end
        check("sync_to_tick_bit_count", idx, 8);

        // Sync on a tick cycle suppresses that tick
        step(9);
        bus.sync = 1'b1;
        @(negedge clk); model_step();
        check("sync_suppresses_tick", int'(bus.tick_os), 0);
        @(posedge clk); #1;
        bus.sync = 1'b0;
        check("phase_after_sync_on_tick", int'(bus.os_phase), 8);
        wait_tick(30, n, b); check("sync_on_tick_period", n, 10);

        // Disable for 10 cycles at cnt=40, with a load while disabled
        pulse_load(100, 0);
        wait_tick(30, n, b); check("load_100_tick", n, 9);
        step(59);
        check("phase_before_disable", int'(bus.os_phase), 10);
        bus.en = 1'b0; dis_ticks = 0;
        for (int k = 0; k < 10; k++) begin
            if (k == 3) begin bus.div_int = DIV_W'(7); bus.div_frac = '0; bus.div_load = 1'b1; end
            if (k == 4) bus.div_load = 1'b0;
            @(negedge clk); model_step();
            if (bus.tick_os || bus.tick_bit) dis_ticks++;
            @(posedge clk); #1;
        end
        check("ticks_while_disabled", dis_ticks, 0);
        check("phase_frozen", int'(bus.os_phase), 10);
        bus.en = 1'b1;
        wait_tick(100, n, b); check("resume_after_disable", n, 41);
        wait_tick(30, n, b);  check("disabled_load_period", n, 7);

        // Async reset on a tick cycle with a pending load
        pulse_load(3, 0);
        step(5);
        check("tick_before_reset", int'(bus.tick_os), 1);
        #1 reset = 1'b0;
        #1;
        check("reset_tick_os", int'(bus.tick_os), 0);
        check("reset_tick_bit", int'(bus.tick_bit), 0);
        check("reset_os_phase", int'(bus.os_phase), 0);
        step(2);
        reset = 1'b1;
        wait_tick(400, n, b); check("post_reset_first", n, 162);
        wait_tick(400, n, b); check("post_reset_second", n, 162);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
